// File: rtl/fpu_if.sv
// Operand and result bundle for the single-precision FPU.
// No handshake: the unit accepts one operation every clock and presents its
// result and flags exactly two clocks later; every output is a registered,
// always-valid view of the operation issued two edges earlier.
interface fpu_if;
   logic [1:0]  rmode;
   logic [2:0]  fpu_op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] out;
   logic        inf;
   logic        snan;
   logic        qnan;
   logic        ine;
   logic        overflow;
   logic        underflow;
   logic        zero;
   logic        div_by_zero;

   modport master (
      output rmode, fpu_op, opa, opb,
      input  out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
   );

   modport slave (
      input  rmode, fpu_op, opa, opb,
      output out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
   );
endinterface

// File: rtl/fpu.sv
// Two-stage IEEE-754 binary32 add/sub/mul/div unit with flush-to-zero
// denormals, four rounding modes and per-result exception flags.
module fpu (
   input  logic  clk,
   input  logic  rst_n,
   fpu_if.slave  bus
);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;
   localparam logic [30:0] INF31 = 31'h7F80_0000;
   localparam logic [30:0] MAX31 = 31'h7F7F_FFFF;

   logic [31:0] s1_opa, s1_opb;
   logic [2:0]  s1_op;
   logic [1:0]  s1_rm;

   // Stage 1: capture operands, operation and rounding mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_opa <= '0;
         s1_opb <= '0;
         s1_op  <= '0;
         s1_rm  <= '0;
      end else begin
         s1_opa <= bus.opa;
         s1_opb <= bus.opb;
         s1_op  <= bus.fpu_op;
         s1_rm  <= bus.rmode;
      end
   end

   // Operand decode; denormals are treated as signed zero.
   logic       sa, sb, sb_eff, eff_sub;
   logic [7:0] ea, eb;
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_snan;
   logic [23:0] ma, mb;

   assign sa       = s1_opa[31];
   assign sb       = s1_opb[31];
   assign ea       = s1_opa[30:23];
   assign eb       = s1_opb[30:23];
   assign a_zero   = (ea == 8'd0);
   assign b_zero   = (eb == 8'd0);
   assign a_inf    = (ea == 8'hFF) && (s1_opa[22:0] == 23'd0);
   assign b_inf    = (eb == 8'hFF) && (s1_opb[22:0] == 23'd0);
   assign a_nan    = (ea == 8'hFF) && (s1_opa[22:0] != 23'd0);
   assign b_nan    = (eb == 8'hFF) && (s1_opb[22:0] != 23'd0);
   assign any_snan = (a_nan && !s1_opa[22]) || (b_nan && !s1_opb[22]);
   assign ma       = a_zero ? 24'd0 : {1'b1, s1_opa[22:0]};
   assign mb       = b_zero ? 24'd0 : {1'b1, s1_opb[22:0]};
   assign sb_eff   = sb ^ (s1_op == 3'd1);
   assign eff_sub  = sa ^ sb_eff;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++)
         if (v[i]) lzc27 = 5'(26 - i);
   endfunction

   // Pre-rounding result: 24-bit mantissa with hidden bit, guard, round, sticky.
   logic               pr_sign, pr_g, pr_r, pr_s;
   logic signed [11:0] pr_exp;
   logic [23:0]        pr_man;

   logic        a_big;
   logic [7:0]  ex, ey, d_exp;
   logic [4:0]  d_sh, lz;
   logic [23:0] mx, my;
   logic [55:0] y_sh;
   logic [26:0] x_w, y_w, sum_n;
   logic [27:0] sum;
   logic [47:0] prod;
   logic [26:0] quo;
   logic [25:0] rem;

   // Datapath for all three arithmetic kinds; the op selects which feeds rounding.
   always_comb begin
      a_big = ({1'b0, a_zero ? 31'd0 : s1_opa[30:0]} >= {1'b0, b_zero ? 31'd0 : s1_opb[30:0]});
      ex    = a_big ? ea : eb;
      ey    = a_big ? eb : ea;
      mx    = a_big ? ma : mb;
      my    = a_big ? mb : ma;
      d_exp = ex - ey;
      d_sh  = (d_exp > 8'd27) ? 5'd27 : d_exp[4:0];
      y_sh  = {my, 32'd0} >> d_sh;
      x_w   = {mx, 3'b000};
      y_w   = {y_sh[55:30], |y_sh[29:0]};
      sum   = eff_sub ? ({1'b0, x_w} - {1'b0, y_w}) : ({1'b0, x_w} + {1'b0, y_w});
      lz    = lzc27(sum[26:0]);
      sum_n = sum[26:0] << lz;

      prod = ma * mb;

      // Restoring division: one quotient bit per step, remainder folds into sticky.
      rem = {2'b00, ma};
      quo = '0;
      for (int i = 26; i >= 0; i--) begin
         if (rem >= {2'b00, mb}) begin
            quo[i] = 1'b1;
            rem    = rem - {2'b00, mb};
         end
         rem = {rem[24:0], 1'b0};
      end

      pr_sign = sa ^ sb;
      pr_exp  = '0;
      pr_man  = '0;
      pr_g    = 1'b0;
      pr_r    = 1'b0;
      pr_s    = 1'b0;
      case (s1_op[1:0])
         2'd0, 2'd1: begin
            pr_sign = a_big ? sa : sb_eff;
            if (sum[27]) begin
               pr_man = sum[27:4];
               pr_g   = sum[3];
               pr_r   = sum[2];
               pr_s   = sum[1] | sum[0];
               pr_exp = $signed({4'd0, ex}) + 12'sd1;
            end else begin
               pr_man = sum_n[26:3];
               pr_g   = sum_n[2];
               pr_r   = sum_n[1];
               pr_s   = sum_n[0];
               pr_exp = $signed({4'd0, ex}) - $signed({7'd0, lz});
            end
         end
         2'd2: begin
            if (prod[47]) begin
               pr_man = prod[47:24];
               pr_g   = prod[23];
               pr_r   = prod[22];
               pr_s   = |prod[21:0];
               pr_exp = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd126;
            end else begin
               pr_man = prod[46:23];
               pr_g   = prod[22];
               pr_r   = prod[21];
               pr_s   = |prod[20:0];
               pr_exp = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
            end
         end
         default: begin
            if (quo[26]) begin
               pr_man = quo[26:3];
               pr_g   = quo[2];
               pr_r   = quo[1];
               pr_s   = quo[0] | (rem != 26'd0);
               pr_exp = $signed({4'd0, ea}) - $signed({4'd0, eb}) + 12'sd127;
            end else begin
               pr_man = quo[25:2];
               pr_g   = quo[1];
               pr_r   = quo[0];
               pr_s   = (rem != 26'd0);
               pr_exp = $signed({4'd0, ea}) - $signed({4'd0, eb}) + 12'sd126;
            end
         end
      endcase
   end

   logic               lost, inc, ovf_inf;
   logic [24:0]        rnd;
   logic [23:0]        rnd_man;
   logic signed [11:0] rnd_exp;

   // Rounding increment per mode; a mantissa carry-out bumps the exponent.
   always_comb begin
      lost = pr_g | pr_r | pr_s;
      case (s1_rm)
         2'd0:    inc = pr_g & (pr_r | pr_s | pr_man[0]);
         2'd1:    inc = 1'b0;
         2'd2:    inc = ~pr_sign & lost;
         default: inc = pr_sign & lost;
      endcase
      rnd = {1'b0, pr_man} + {24'd0, inc};
      if (rnd[24]) begin
         rnd_man = rnd[24:1];
         rnd_exp = pr_exp + 12'sd1;
      end else begin
         rnd_man = rnd[23:0];
         rnd_exp = pr_exp;
      end
      ovf_inf = (s1_rm == 2'd0) || (s1_rm == 2'd2 && !pr_sign) || (s1_rm == 2'd3 && pr_sign);
   end

   logic [31:0] n_out;
   logic        n_snan, n_qnan, n_ine, n_ovf, n_unf, n_dbz, use_norm;

   // Special-operand handling, then overflow/underflow on the rounded value.
   always_comb begin
      n_out    = '0;
      n_snan   = 1'b0;
      n_qnan   = 1'b0;
      n_ine    = 1'b0;
      n_ovf    = 1'b0;
      n_unf    = 1'b0;
      n_dbz    = 1'b0;
      use_norm = 1'b0;
      if (s1_op[2]) begin
         n_out  = QNAN;
         n_qnan = 1'b1;
      end else if (a_nan || b_nan) begin
         n_out  = QNAN;
         n_qnan = 1'b1;
         n_snan = any_snan;
      end else begin
         case (s1_op[1:0])
            2'd0, 2'd1: begin
               if (a_inf && b_inf && eff_sub) begin
                  n_out = QNAN; n_qnan = 1'b1;
               end else if (a_inf)           n_out = {sa, INF31};
               else if (b_inf)               n_out = {sb_eff, INF31};
               else if (a_zero && b_zero)    n_out = {eff_sub ? (s1_rm == 2'd3) : sa, 31'd0};
               else if (sum == 28'd0)        n_out = {(s1_rm == 2'd3), 31'd0};
               else                          use_norm = 1'b1;
            end
            2'd2: begin
               if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                  n_out = QNAN; n_qnan = 1'b1;
               end else if (a_inf || b_inf)  n_out = {sa ^ sb, INF31};
               else if (a_zero || b_zero)    n_out = {sa ^ sb, 31'd0};
               else                          use_norm = 1'b1;
            end
            default: begin
               if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                  n_out = QNAN; n_qnan = 1'b1;
               end else if (a_inf)           n_out = {sa ^ sb, INF31};
               else if (b_zero) begin
                  n_out = {sa ^ sb, INF31}; n_dbz = 1'b1;
               end else if (b_inf || a_zero) n_out = {sa ^ sb, 31'd0};
               else                          use_norm = 1'b1;
            end
         endcase
      end
      if (use_norm) begin
         n_ine = lost;
         if (rnd_exp >= 12'sd255) begin
            n_ovf = 1'b1;
            n_ine = 1'b1;
            n_out = {pr_sign, ovf_inf ? INF31 : MAX31};
         end else if (rnd_exp <= 12'sd0) begin
            n_unf = 1'b1;
            n_ine = 1'b1;
            n_out = {pr_sign, 31'd0};
         end else begin
            n_out = {pr_sign, rnd_exp[7:0], rnd_man[22:0]};
         end
      end
   end

   // Stage 2: register the result and its flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out         <= '0;
         bus.inf         <= 1'b0;
         bus.snan        <= 1'b0;
         bus.qnan        <= 1'b0;
         bus.ine         <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.underflow   <= 1'b0;
         bus.zero        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.out         <= n_out;
         bus.inf         <= (n_out[30:0] == INF31);
         bus.snan        <= n_snan;
         bus.qnan        <= n_qnan;
         bus.ine         <= n_ine;
         bus.overflow    <= n_ovf;
         bus.underflow   <= n_unf;
         bus.zero        <= (n_out[30:0] == 31'd0);
         bus.div_by_zero <= n_dbz;
      end
   end
endmodule

// File: tb/tb_fpu.sv
// Directed bench for the FPU: hand-computed vectors, expected-result queue,
// immediate assertions at every comparison point.
module tb_fpu;
   localparam logic [7:0] F_INF  = 8'h80;
   localparam logic [7:0] F_SNAN = 8'h40;
   localparam logic [7:0] F_QNAN = 8'h20;
   localparam logic [7:0] F_INE  = 8'h10;
   localparam logic [7:0] F_OVF  = 8'h08;
   localparam logic [7:0] F_UNF  = 8'h04;
   localparam logic [7:0] F_ZERO = 8'h02;
   localparam logic [7:0] F_DBZ  = 8'h01;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [39:0] exp_q[$];

   fpu_if bus ();

   fpu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] flags_now();
      return {bus.inf, bus.snan, bus.qnan, bus.ine, bus.overflow,
              bus.underflow, bus.zero, bus.div_by_zero};
   endfunction

   // Driver: apply one operation and queue its expected result
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [1:0] rm, input logic [31:0] eo, input logic [7:0] ef);
      bus.opa    = a;
      bus.opb    = b;
      bus.fpu_op = op;
      bus.rmode  = rm;
      exp_q.push_back({ef, eo});
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fixed(input string tag, input logic [31:0] eo, input logic [7:0] ef);
      checks++;
      assert (bus.out === eo) else begin
         errors++;
         $error("FAIL %s out: got %h expected %h", tag, bus.out, eo);
      end
      checks++;
      assert (flags_now() === ef) else begin
         errors++;
         $error("FAIL %s flags: got %b expected %b", tag, flags_now(), ef);
      end
   endtask

   // Scoreboard: compare the current outputs against the oldest expectation
   task automatic check_next(input string tag);
      logic [39:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s queue: got empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_fixed(tag, e[31:0], e[39:32]);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [1:0] rm,
                      input logic [31:0] eo, input logic [7:0] ef);
      issue(a, b, op, rm, eo, ef);
      tick();
      check_next(tag);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.opa    = '0;
      bus.opb    = '0;
      bus.fpu_op = '0;
      bus.rmode  = '0;
      #2;
      check_fixed("reset_state", 32'h0000_0000, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;

      run("add_1p2",   32'h3F80_0000, 32'h4000_0000, 3'd0, 2'd0, 32'h4040_0000, 8'h00);
      run("sub_1m2",   32'h3F80_0000, 32'h4000_0000, 3'd1, 2'd0, 32'hBF80_0000, 8'h00);

      // back-to-back: results leave in issue order on consecutive cycles
      issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 2'd0, 32'h4040_0000, 8'h00);
      issue(32'h4000_0000, 32'h4040_0000, 3'd2, 2'd0, 32'h40C0_0000, 8'h00);
      check_next("pipe_add");
      tick();
      check_next("pipe_mul");

      run("div_rne",   32'h3F80_0000, 32'h4040_0000, 3'd3, 2'd0, 32'h3EAA_AAAB, F_INE);
      run("div_rz",    32'h3F80_0000, 32'h4040_0000, 3'd3, 2'd1, 32'h3EAA_AAAA, F_INE);
      run("div_rup",   32'h3F80_0000, 32'h4040_0000, 3'd3, 2'd2, 32'h3EAA_AAAB, F_INE);
      run("div_rdn",   32'h3F80_0000, 32'h4040_0000, 3'd3, 2'd3, 32'h3EAA_AAAA, F_INE);
      run("div_by_0",  32'h3F80_0000, 32'h0000_0000, 3'd3, 2'd0, 32'h7F80_0000, F_INF | F_DBZ);
      run("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 3'd1, 2'd0, 32'h7FC0_0000, F_QNAN);
      run("snan_add",  32'h7FA0_0000, 32'h3F80_0000, 3'd0, 2'd0, 32'h7FC0_0000, F_SNAN | F_QNAN);
      run("zero_x_inf",32'h0000_0000, 32'h7F80_0000, 3'd2, 2'd0, 32'h7FC0_0000, F_QNAN);
      run("ovf_rne",   32'h7F7F_FFFF, 32'h4000_0000, 3'd2, 2'd0, 32'h7F80_0000, F_INF | F_OVF | F_INE);
      run("ovf_rz",    32'h7F7F_FFFF, 32'h4000_0000, 3'd2, 2'd1, 32'h7F7F_FFFF, F_OVF | F_INE);
      run("ovf_rdn",   32'h7F7F_FFFF, 32'h4000_0000, 3'd2, 2'd3, 32'h7F7F_FFFF, F_OVF | F_INE);
      run("unf_mul",   32'h0080_0000, 32'h3F00_0000, 3'd2, 2'd0, 32'h0000_0000, F_UNF | F_ZERO | F_INE);
      run("fin_div_inf", 32'h3F80_0000, 32'hFF80_0000, 3'd3, 2'd0, 32'h8000_0000, F_ZERO);
      run("reserved_op", 32'h3F80_0000, 32'h3F80_0000, 3'd5, 2'd0, 32'h7FC0_0000, F_QNAN);

      // reset mid-stream: outputs clear without waiting for a clock edge
      issue(32'h4000_0000, 32'h4040_0000, 3'd2, 2'd0, 32'h40C0_0000, 8'h00);
      tick();
      check_next("pre_reset");
      rst_n = 1'b0;
      #1;
      check_fixed("reset_mid", 32'h0000_0000, 8'h00);
      exp_q.delete();
      tick();
      rst_n = 1'b1;

      run("post_reset_1p1", 32'h3F80_0000, 32'h3F80_0000, 3'd0, 2'd0, 32'h4000_0000, 8'h00);
      run("cancel_rne", 32'h3F80_0000, 32'h3F80_0000, 3'd1, 2'd0, 32'h0000_0000, F_ZERO);
      run("cancel_rdn", 32'h3F80_0000, 32'h3F80_0000, 3'd1, 2'd3, 32'h8000_0000, F_ZERO);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
